// File: rtl/rv_board_status.sv
// Board bring-up status block: sequences the downstream core reset, tracks halt,
// and drives status LEDs with per-channel level/latch/stretch/heartbeat behaviour.
module rv_board_status #(
    parameter int CLOCK_FREQ      = 100_000_000,
    parameter int NUM_LEDS        = 2,
    parameter int RST_HOLD_CYCLES = 16,
    parameter int BLINK_HZ        = 2,
    parameter int STRETCH_MS      = 50
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  ebreak,
    input  logic                  clr,
    input  logic [NUM_LEDS-1:0]   evt,
    input  logic [2*NUM_LEDS-1:0] mode,
    output logic                  core_rst_n,
    output logic                  halted,
    output logic [NUM_LEDS-1:0]   led
);
    localparam int BLINK_HALF     = CLOCK_FREQ / (2 * BLINK_HZ);
    localparam int STRETCH_CYCLES = (CLOCK_FREQ / 1000) * STRETCH_MS;
    localparam int SC_W = $clog2(STRETCH_CYCLES + 1);
    localparam int HB_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int HC_W = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;

    localparam logic [SC_W-1:0] SC_LOAD   = SC_W'(STRETCH_CYCLES);
    localparam logic [SC_W-1:0] SC_ONE    = SC_W'(1'b1);
    localparam logic [SC_W-1:0] SC_ZERO   = {SC_W{1'b0}};
    localparam logic [HB_W-1:0] HB_LAST   = HB_W'(BLINK_HALF - 1);
    localparam logic [HB_W-1:0] HB_ONE    = HB_W'(1'b1);
    localparam logic [HB_W-1:0] HB_ZERO   = {HB_W{1'b0}};
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(RST_HOLD_CYCLES - 1);
    localparam logic [HC_W-1:0] HC_ONE    = HC_W'(1'b1);
    localparam logic [HC_W-1:0] HC_ZERO   = {HC_W{1'b0}};

    if (BLINK_HALF < 1) begin : g_bad_blink
        $error("rv_board_status: BLINK_HALF must be at least 1");
    end
    if (STRETCH_CYCLES < 1) begin : g_bad_stretch
        $error("rv_board_status: STRETCH_CYCLES must be at least 1");
    end
    if (NUM_LEDS < 1 || NUM_LEDS > 16) begin : g_bad_leds
        $error("rv_board_status: NUM_LEDS must be 1..16");
    end
    if (RST_HOLD_CYCLES < 1) begin : g_bad_hold
        $error("rv_board_status: RST_HOLD_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_HOLD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [HC_W-1:0]     r_hold_cnt;
    logic [HC_W-1:0]     w_hold_cnt_nxt;
    logic [HB_W-1:0]     r_hb_cnt;
    logic [HB_W-1:0]     w_hb_cnt_nxt;
    logic                r_phase;
    logic                w_phase_nxt;
    logic                w_hb_led;
    logic [NUM_LEDS-1:0] r_latch;
    logic [NUM_LEDS-1:0] w_latch_nxt;
    logic [SC_W-1:0]     r_str [NUM_LEDS];
    logic [SC_W-1:0]     w_str_nxt [NUM_LEDS];
    logic [NUM_LEDS-1:0] w_led_nxt;
    logic                r_core_rst_n;
    logic                r_halted;
    logic [NUM_LEDS-1:0] r_led;

    // Sequencer state register and reset-hold counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_RESET;
            r_hold_cnt <= HC_ZERO;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
        end
    end

    // Sequencer next state; a dropped enable always wins over halt and clear
    always_comb begin
        w_state_nxt    = r_state;
        w_hold_cnt_nxt = r_hold_cnt;
        case (r_state)
            ST_RESET: begin
                w_state_nxt    = ST_HOLD;
                w_hold_cnt_nxt = HC_ZERO;
            end
            ST_HOLD: begin
                if (!en) begin
                    w_hold_cnt_nxt = HC_ZERO;
                end else if (r_hold_cnt == HOLD_LAST) begin
                    w_state_nxt    = ST_RUN;
                    w_hold_cnt_nxt = HC_ZERO;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + HC_ONE;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    w_state_nxt    = ST_HOLD;
                    w_hold_cnt_nxt = HC_ZERO;
                end else if (ebreak) begin
                    w_state_nxt = ST_HALT;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_HALT: begin
                if (!en || clr) begin
                    w_state_nxt    = ST_HOLD;
                    w_hold_cnt_nxt = HC_ZERO;
                end else begin
                    w_state_nxt = ST_HALT;
                end
            end
            default: begin
                w_state_nxt    = ST_RESET;
                w_hold_cnt_nxt = HC_ZERO;
            end
        endcase
    end

    // Heartbeat phase and per-channel latch/stretch/LED selection
    always_comb begin
        w_hb_cnt_nxt = (r_hb_cnt == HB_LAST) ? HB_ZERO : (r_hb_cnt + HB_ONE);
        w_phase_nxt  = r_phase ^ (r_hb_cnt == HB_LAST);
        w_latch_nxt  = r_latch;
        w_led_nxt    = {NUM_LEDS{1'b0}};
        if (w_state_nxt == ST_HALT) begin
            w_hb_led = 1'b1;
        end else if (w_state_nxt == ST_RUN) begin
            w_hb_led = w_phase_nxt;
        end else begin
            w_hb_led = 1'b0;
        end
        for (int i = 0; i < NUM_LEDS; i++) begin
            // latch and stretch state keep running whatever the mode, so a mode switch loses nothing
            w_latch_nxt[i] = evt[i] | (r_latch[i] & ~clr);
            if (evt[i]) begin
                w_str_nxt[i] = SC_LOAD;
            end else if (r_str[i] != SC_ZERO) begin
                w_str_nxt[i] = r_str[i] - SC_ONE;
            end else begin
                w_str_nxt[i] = SC_ZERO;
            end
            case (mode[2*i +: 2])
                2'b00:   w_led_nxt[i] = evt[i];
                2'b01:   w_led_nxt[i] = w_latch_nxt[i];
                2'b10:   w_led_nxt[i] = (w_str_nxt[i] != SC_ZERO);
                2'b11:   w_led_nxt[i] = w_hb_led;
                default: w_led_nxt[i] = 1'b0;
            endcase
        end
    end

    // Channel state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hb_cnt     <= HB_ZERO;
            r_phase      <= 1'b0;
            r_latch      <= {NUM_LEDS{1'b0}};
            r_core_rst_n <= 1'b0;
            r_halted     <= 1'b0;
            r_led        <= {NUM_LEDS{1'b0}};
            for (int i = 0; i < NUM_LEDS; i++) begin
                r_str[i] <= SC_ZERO;
            end
        end else begin
            r_hb_cnt     <= w_hb_cnt_nxt;
            r_phase      <= w_phase_nxt;
            r_latch      <= w_latch_nxt;
            r_core_rst_n <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_HALT);
            r_halted     <= (w_state_nxt == ST_HALT);
            r_led        <= w_led_nxt;
            for (int i = 0; i < NUM_LEDS; i++) begin
                r_str[i] <= w_str_nxt[i];
            end
        end
    end

    assign core_rst_n = r_core_rst_n;
    assign halted     = r_halted;
    assign led        = r_led;

endmodule

// File: doc/rv_board_status.md
RV_BOARD_STATUS -- requirements
Module: rv_board_status

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 100_000_000, clock frequency in Hz.
REQ-002 SHALL have parameter NUM_LEDS, default 2, number of status LED channels (1..16).
REQ-003 SHALL have parameter RST_HOLD_CYCLES, default 16, core reset hold length in cycles (>=1).
REQ-004 SHALL have parameter BLINK_HZ, default 2, heartbeat blink rate; BLINK_HALF = CLOCK_FREQ/(2*BLINK_HZ), elaboration error if BLINK_HALF < 1.
REQ-005 SHALL have parameter STRETCH_MS, default 50, pulse-stretch length; STRETCH_CYCLES = (CLOCK_FREQ/1000)*STRETCH_MS, elaboration error if < 1.
REQ-006 SHALL have port clk  input  1  system clock; one clock, all state on its rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port en  input  1  run enable; low forces core back into reset hold.
REQ-009 SHALL have port ebreak  input  1  core halt indication, level.
REQ-010 SHALL have port clr  input  1  clear latches / restart from HALT, single-cycle pulse.
REQ-011 SHALL have port evt  input  NUM_LEDS  per-channel event/level source.
REQ-012 SHALL have port mode  input  2*NUM_LEDS  per-channel mode, channel i at bits [2i+1:2i].
REQ-013 SHALL have port core_rst_n  output  1  active-low reset to downstream core.
REQ-014 SHALL have port halted  output  1  high while in HALT.
REQ-015 SHALL have port led  output  NUM_LEDS  LED drive, active-high.

Function
REQ-016 SHALL implement sequencer FSM states RESET, HOLD, RUN, HALT; all outputs registered.
REQ-017 SHALL go RESET->HOLD on first clk after rst deasserts, clearing hold counter to 0.
REQ-018 SHALL in HOLD increment hold counter each cycle with en=1; at count RST_HOLD_CYCLES-1 go to RUN; core_rst_n=1 from the first RUN cycle, i.e. RST_HOLD_CYCLES+1 clocks after rst deassert.
REQ-019 SHALL in HOLD with en=0 keep the hold counter at 0.
REQ-020 SHALL in RUN or HALT with en=0 go to HOLD (counter 0, core_rst_n=0 next cycle); en=0 has priority over ebreak and clr.
REQ-021 SHALL in RUN with ebreak=1 go to HALT; halted=1 and core_rst_n stays 1.
REQ-022 SHALL in HALT stay until clr=1, then go to HOLD (core re-reset); ebreak ignored in HALT.
REQ-023 SHALL decode per-channel mode: 00 level, 01 latch, 10 stretch, 11 heartbeat.
REQ-024 Level: led[i] SHALL equal evt[i] delayed one cycle.
REQ-025 Latch: led[i] SHALL set the cycle after evt[i]=1 and clear the cycle after clr=1 with evt[i]=0; simultaneous evt and clr -> set wins.
REQ-026 Stretch: evt[i]=1 SHALL load a per-channel counter with STRETCH_CYCLES; led[i]=1 while counter nonzero, counting down 1/cycle; evt during stretch reloads (retrigger), no accumulation.
REQ-027 Heartbeat: one shared counter SHALL wrap 0..BLINK_HALF-1 and toggle a phase bit at wrap; led[i]=phase in RUN, 1 in HALT, 0 in RESET/HOLD; evt[i] ignored.
REQ-028 SHALL use per-channel counter width $clog2(STRETCH_CYCLES+1) and heartbeat counter width $clog2(BLINK_HALF); no overflow possible.
REQ-029 SHALL apply a mode change on the next cycle without clearing that channel's latch/counter state.
REQ-030 Channel logic (REQ-024..026) SHALL operate in every FSM state, including HOLD and HALT.

Reset
REQ-031 rst=1 SHALL asynchronously force state RESET, core_rst_n=0, halted=0, led=0, all counters, latches and heartbeat phase to 0.
REQ-032 rst asserted mid-RUN or mid-stretch SHALL abort immediately; after release the full REQ-017/018 sequence repeats.

Verification (CLOCK_FREQ=1000, NUM_LEDS=4, RST_HOLD_CYCLES=4, BLINK_HZ=100, STRETCH_MS=3)
REQ-033 Release rst, en=1 -> core_rst_n rises exactly 5 clocks later; pull en=0 at clock 3 -> counter restarts, rise delayed accordingly.
REQ-034 mode=11 on ch3 in RUN -> led[3] toggles every 5 cycles; ebreak=1 -> halted=1 and led[3]=1 next cycle; clr -> HOLD, core_rst_n=0, led[3]=0.
REQ-035 Ch1 latch: evt pulse -> led[1]=1 next cycle and held; clr alone -> 0; clr+evt same cycle -> stays 1.
REQ-036 Ch2 stretch (3 cycles): 1-cycle evt -> led[2] high exactly 3 cycles; second evt on 2nd high cycle -> high 3 more cycles from retrigger.
REQ-037 Assert rst mid-stretch with latch set -> all led=0, core_rst_n=0 without a clock edge.
